// File: rtl/sprite_line_renderer.sv
// Sprite line renderer: scans object RAM during the last physical line of each
// logical line, rasterises hits into a back line buffer, and shows the front buffer.
module sprite_line_renderer #(
    parameter int MAX_SPRITES  = 2,
    parameter int BITMAP_BYTES = 55,
    parameter int LINE_PIXELS  = 160,
    parameter int V_LAST       = 524
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [9:0]                         pix_x,
    input  logic [9:0]                         pix_y,
    input  logic                               visible,
    input  logic                               line_start,
    output logic [$clog2(4*MAX_SPRITES)-1:0]   obj_rd_addr,
    input  logic [7:0]                         obj_rd_data,
    output logic [5:0]                         bmp_rd_addr,
    input  logic [7:0]                         bmp_rd_data,
    output logic                               pixel_on,
    output logic                               busy,
    output logic                               overrun
);

    localparam int OBJ_AW = $clog2(4*MAX_SPRITES);
    localparam int IDX_W  = (MAX_SPRITES > 1) ? $clog2(MAX_SPRITES) : 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CLEAR    = 3'd1,
        OBJ_RD   = 3'd2,
        CHECK    = 3'd3,
        PIX_ADDR = 3'd4,
        PIX_DATA = 3'd5,
        NEXT     = 3'd6
    } state_t;

    state_t                   state_q, state_d;
    logic [LINE_PIXELS-1:0]   buf0_q, buf0_d, buf1_q, buf1_d;
    logic [LINE_PIXELS-1:0]   back_s, back_d, front_s;
    logic                     sel_q, sel_d;
    logic [7:0]               t_q, t_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [2:0]               cnt_q, cnt_d;
    logic [7:0]               x_q, x_d, y_q, y_d, off_q, off_d, size_q, size_d;
    logic [3:0]               sx_q, sx_d;
    logic [7:0]               bitoff_q, bitoff_d;
    logic [8:0]               baddr_q, baddr_d;
    logic [OBJ_AW-1:0]        obj_addr_q, obj_addr_d;
    logic [5:0]               bmp_addr_q, bmp_addr_d;
    logic                     pixel_q, pixel_d;
    logic                     busy_q, busy_d;
    logic                     overrun_q, overrun_d;

    logic                     start_s, swap_s;
    logic [7:0]               t_next_s, row_s, bitoff_next_s;
    logic [8:0]               baddr_next_s, px_s;
    logic [4:0]               width_s, height_s;
    logic                     hit_s;
    logic [7:0]               pix_idx_s;
    logic                     unused_pix_s;

    assign unused_pix_s = ^pix_x[1:0];

    // Line-boundary decode and sprite geometry shared by the FSM.
    always_comb begin
        start_s       = line_start && ((pix_y[1:0] == 2'b11) || (pix_y == 10'(V_LAST)));
        swap_s        = line_start && (pix_y[1:0] == 2'b00);
        t_next_s      = (pix_y == 10'(V_LAST)) ? 8'd0 : (pix_y[9:2] + 8'd1);
        width_s       = {1'b0, size_q[7:4]} + 5'd1;
        height_s      = {1'b0, size_q[3:0]} + 5'd1;
        hit_s         = (t_q >= y_q) && ({1'b0, t_q} < ({1'b0, y_q} + {4'd0, height_s}));
        row_s         = t_q - y_q;
        px_s          = {1'b0, x_q} + {5'd0, sx_q};
        front_s       = sel_q ? buf1_q : buf0_q;
        back_s        = sel_q ? buf0_q : buf1_q;
        pix_idx_s     = pix_x[9:2];
    end

    // Render FSM next state, buffer updates and registered-output next values.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        t_d       = t_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        x_d       = x_q;
        y_d       = y_q;
        off_d     = off_q;
        size_d    = size_q;
        sx_d      = sx_q;
        back_d    = back_s;
        overrun_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_s) begin
                    state_d = CLEAR;
                    t_d     = t_next_s;
                end else begin
                    state_d = IDLE;
                end
            end
            CLEAR: begin
                back_d  = '0;
                idx_d   = '0;
                cnt_d   = 3'd0;
                state_d = OBJ_RD;
            end
            OBJ_RD: begin
                // Each captured byte is the RAM reply to the address of the previous cycle.
                cnt_d = cnt_q + 3'd1;
                case (cnt_q)
                    3'd1:    x_d    = obj_rd_data;
                    3'd2:    y_d    = obj_rd_data;
                    3'd3:    off_d  = obj_rd_data;
                    3'd4:    size_d = obj_rd_data;
                    default: cnt_d  = cnt_q + 3'd1;
                endcase
                if (cnt_q == 3'd4) begin
                    state_d = CHECK;
                end else begin
                    state_d = OBJ_RD;
                end
            end
            CHECK: begin
                if (hit_s) begin
                    sx_d    = 4'd0;
                    state_d = PIX_ADDR;
                end else begin
                    state_d = NEXT;
                end
            end
            PIX_ADDR: begin
                state_d = PIX_DATA;
            end
            PIX_DATA: begin
                if (bmp_rd_data[bitoff_q[2:0]] && (baddr_q < 9'(BITMAP_BYTES))
                        && (px_s < 9'(LINE_PIXELS))) begin
                    back_d[px_s[7:0]] = 1'b1;
                end else begin
                    back_d = back_s;
                end
                if (({1'b0, sx_q} + 5'd1) < width_s) begin
                    sx_d    = sx_q + 4'd1;
                    state_d = PIX_ADDR;
                end else begin
                    state_d = NEXT;
                end
            end
            NEXT: begin
                if ((int'(idx_q) + 1) < MAX_SPRITES) begin
                    idx_d   = idx_q + 1'b1;
                    cnt_d   = 3'd0;
                    state_d = OBJ_RD;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A swap always happens; if it lands mid-render the render is abandoned unwritten.
        if (swap_s) begin
            sel_d = ~sel_q;
            if (state_q != IDLE) begin
                state_d   = IDLE;
                overrun_d = 1'b1;
                back_d    = back_s;
            end else begin
                overrun_d = 1'b0;
            end
        end else begin
            sel_d = sel_q;
        end

        if (sel_q) begin
            buf0_d = back_d;
            buf1_d = buf1_q;
        end else begin
            buf0_d = buf0_q;
            buf1_d = back_d;
        end

        bitoff_next_s = 8'(row_s * {3'd0, width_s}) + {4'd0, sx_d};
        baddr_next_s  = {1'b0, off_q} + {4'd0, bitoff_next_s[7:3]};

        if (state_d == PIX_ADDR) begin
            bitoff_d   = bitoff_next_s;
            baddr_d    = baddr_next_s;
            bmp_addr_d = baddr_next_s[5:0];
        end else begin
            bitoff_d   = bitoff_q;
            baddr_d    = baddr_q;
            bmp_addr_d = 6'd0;
        end

        if ((state_d == OBJ_RD) && (cnt_d < 3'd4)) begin
            obj_addr_d = OBJ_AW'(int'(idx_d) * 4 + int'(cnt_d));
        end else begin
            obj_addr_d = '0;
        end

        busy_d = (state_d != IDLE);

        if (visible && ({24'd0, pix_idx_s} < LINE_PIXELS)) begin
            pixel_d = front_s[pix_idx_s];
        end else begin
            pixel_d = 1'b0;
        end
    end

    // State, buffers, captured attributes and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            buf0_q     <= '0;
            buf1_q     <= '0;
            sel_q      <= 1'b0;
            t_q        <= 8'd0;
            idx_q      <= '0;
            cnt_q      <= 3'd0;
            x_q        <= 8'd0;
            y_q        <= 8'd0;
            off_q      <= 8'd0;
            size_q     <= 8'd0;
            sx_q       <= 4'd0;
            bitoff_q   <= 8'd0;
            baddr_q    <= 9'd0;
            obj_addr_q <= '0;
            bmp_addr_q <= 6'd0;
            pixel_q    <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            sel_q      <= sel_d;
            t_q        <= t_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            x_q        <= x_d;
            y_q        <= y_d;
            off_q      <= off_d;
            size_q     <= size_d;
            sx_q       <= sx_d;
            bitoff_q   <= bitoff_d;
            baddr_q    <= baddr_d;
            obj_addr_q <= obj_addr_d;
            bmp_addr_q <= bmp_addr_d;
            pixel_q    <= pixel_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
        end
    end

    assign obj_rd_addr = obj_addr_q;
    assign bmp_rd_addr = bmp_addr_q;
    assign pixel_on    = pixel_q;
    assign busy        = busy_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_sprite_line_renderer.sv
// Directed bench for sprite_line_renderer with behavioural object/bitmap RAMs
// and hand-computed line-buffer contents.
module tb_sprite_line_renderer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  pix_x, pix_y;
    logic        visible, line_start;
    logic [2:0]  obj_rd_addr;
    logic [7:0]  obj_rd_data, bmp_rd_data;
    logic [5:0]  bmp_rd_addr;
    logic        pixel_on, busy, overrun;

    logic [7:0]  obj_mem [0:7];
    logic [7:0]  bmp_mem [0:63];
    int          checks = 0;
    int          errors = 0;
    int          addr5_cnt = 0;
    int          base;
    logic [159:0] v;

    sprite_line_renderer dut (
        .clk(clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y),
        .visible(visible), .line_start(line_start),
        .obj_rd_addr(obj_rd_addr), .obj_rd_data(obj_rd_data),
        .bmp_rd_addr(bmp_rd_addr), .bmp_rd_data(bmp_rd_data),
        .pixel_on(pixel_on), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM models: data valid one cycle after the address.
    always @(posedge clk) begin
        obj_rd_data <= obj_mem[obj_rd_addr];
        bmp_rd_data <= bmp_mem[bmp_rd_addr];
    end

    // Counts cycles that present bitmap address 5.
    always @(posedge clk) begin
        if (bmp_rd_addr == 6'd5) addr5_cnt <= addr5_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_line(input logic [9:0] y);
        pix_y      = y;
        line_start = 1'b1;
        step();
        line_start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 2000) begin
            step();
            n++;
        end
        check(tag, {159'd0, busy}, 160'd0);
    endtask

    task automatic read_front(output logic [159:0] vec);
        vec     = '0;
        visible = 1'b1;
        for (int p = 0; p < 160; p++) begin
            pix_x = 10'(p * 4);
            step();
            vec[p] = pixel_on;
        end
        visible = 1'b0;
    endtask

    task automatic set_obj(input int i, input logic [7:0] x, input logic [7:0] y,
                           input logic [7:0] off, input logic [7:0] size);
        obj_mem[i*4+0] = x;
        obj_mem[i*4+1] = y;
        obj_mem[i*4+2] = off;
        obj_mem[i*4+3] = size;
    endtask

    function automatic logic [159:0] mask(input int lo, input int hi);
        logic [159:0] m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    initial begin
        rst_n = 1'b0; pix_x = 10'd0; pix_y = 10'd0; visible = 1'b0; line_start = 1'b0;
        for (int i = 0; i < 64; i++) bmp_mem[i] = 8'd0;
        set_obj(0, 8'd0, 8'd200, 8'd0, 8'd0);
        set_obj(1, 8'd0, 8'd200, 8'd0, 8'd0);
        step(); step();

        // Reset state
        check("rst_busy", {159'd0, busy}, 160'd0);
        check("rst_overrun", {159'd0, overrun}, 160'd0);
        check("rst_pixel_on", {159'd0, pixel_on}, 160'd0);
        check("rst_obj_addr", {157'd0, obj_rd_addr}, 160'd0);
        check("rst_bmp_addr", {154'd0, bmp_rd_addr}, 160'd0);
        rst_n = 1'b1;
        step();
        read_front(v);
        check("rst_front", v, 160'd0);

        // 1x1 sprite at x=10, y=5 rendered from pix_y=19
        set_obj(0, 8'd10, 8'd5, 8'd0, 8'h00);
        bmp_mem[0] = 8'h01;
        pulse_line(10'd19);
        check("busy_after_start", {159'd0, busy}, 160'd1);
        wait_idle("idle_1x1");
        pulse_line(10'd20);
        read_front(v);
        check("front_1x1", v, mask(10, 10));
        visible = 1'b1;
        pix_x = 10'd40; step();
        check("px40", {159'd0, pixel_on}, 160'd1);
        pix_x = 10'd43; step();
        check("px43", {159'd0, pixel_on}, 160'd1);
        pix_x = 10'd44; #1;
        check("latency_hold", {159'd0, pixel_on}, 160'd1);
        step();
        check("px44", {159'd0, pixel_on}, 160'd0);
        pix_x = 10'd39; step();
        check("px39", {159'd0, pixel_on}, 160'd0);
        pix_x = 10'd40; visible = 1'b0; step();
        check("not_visible", {159'd0, pixel_on}, 160'd0);

        // 8x8 sprite, row 3 read from bitmap byte 5
        set_obj(0, 8'd20, 8'd30, 8'd2, 8'h77);
        for (int r = 0; r < 8; r++) bmp_mem[2+r] = 8'hFF;
        base = addr5_cnt;
        pulse_line(10'd131);
        wait_idle("idle_8x8");
        check("addr5_reads", 160'(addr5_cnt - base), 160'd8);
        pulse_line(10'd132);
        read_front(v);
        check("front_8x8", v, mask(20, 27));

        // Right-edge clipping, with a start during the render that must be ignored
        set_obj(0, 8'd156, 8'd40, 8'd10, 8'h70);
        bmp_mem[10] = 8'hFF;
        pulse_line(10'd159);
        step(); step();
        pulse_line(10'd163);
        wait_idle("idle_clip");
        pulse_line(10'd164);
        read_front(v);
        check("front_clip", v, mask(156, 159));
        visible = 1'b1; pix_x = 10'd700; step();
        check("px_beyond_line", {159'd0, pixel_on}, 160'd0);
        visible = 1'b0;

        // Bitmap bytes at or past 55 are treated as blank
        set_obj(0, 8'd50, 8'd60, 8'd54, 8'hF0);
        bmp_mem[54] = 8'hFF;
        bmp_mem[55] = 8'hFF;
        pulse_line(10'd239);
        wait_idle("idle_bmp_limit");
        pulse_line(10'd240);
        read_front(v);
        check("front_bmp_limit", v, mask(50, 57));

        // Last frame line renders logical line 0 for the next frame
        set_obj(0, 8'd0, 8'd0, 8'd11, 8'h11);
        bmp_mem[11] = 8'h03;
        pulse_line(10'd524);
        check("vlast_busy", {159'd0, busy}, 160'd1);
        check("vlast_no_overrun", {159'd0, overrun}, 160'd0);
        wait_idle("idle_vlast");
        pulse_line(10'd0);
        read_front(v);
        check("front_line0", v, mask(0, 1));

        // Swap forced while busy
        pulse_line(10'd3);
        step(); step();
        check("busy_before_overrun", {159'd0, busy}, 160'd1);
        pulse_line(10'd4);
        check("overrun_pulse", {159'd0, overrun}, 160'd1);
        check("busy_dropped", {159'd0, busy}, 160'd0);
        step();
        check("overrun_single", {159'd0, overrun}, 160'd0);
        read_front(v);
        check("front_after_overrun", v, 160'd0);

        // Reset in the middle of a render
        set_obj(0, 8'd20, 8'd30, 8'd2, 8'h77);
        pulse_line(10'd131);
        for (int i = 0; i < 12; i++) step();
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {159'd0, busy}, 160'd0);
        step();
        rst_n = 1'b1;
        step();
        step();
        check("midrst_idle", {159'd0, busy}, 160'd0);
        read_front(v);
        check("midrst_front", v, 160'd0);
        pulse_line(10'd132);
        read_front(v);
        check("midrst_back", v, 160'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_line_renderer.md
SPRITE_LINE_RENDERER -- requirements
Module: sprite_line_renderer

Interface
REQ-001 SHALL have parameter MAX_SPRITES, default 2, number of 4-byte object entries scanned per line.
REQ-002 SHALL have parameter BITMAP_BYTES, default 55, size of bitmap memory in bytes.
REQ-003 SHALL have parameter LINE_PIXELS, default 160, logical pixels per line (physical pixel / 4).
REQ-004 SHALL have parameter V_LAST, default 524, last physical line index of the frame.
REQ-005 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port pix_x  input  10  current physical column from the timing generator.
REQ-008 SHALL have port pix_y  input  10  current physical line from the timing generator.
REQ-009 SHALL have port visible  input  1  high in the active display area.
REQ-010 SHALL have port line_start  input  1  one-cycle pulse at the first clock of each physical line.
REQ-011 SHALL have port obj_rd_addr  output  $clog2(4*MAX_SPRITES)  active object RAM byte address.
REQ-012 SHALL have port obj_rd_data  input  8  object RAM data, valid one cycle after its address.
REQ-013 SHALL have port bmp_rd_addr  output  6  bitmap RAM byte address.
REQ-014 SHALL have port bmp_rd_data  input  8  bitmap RAM data, valid one cycle after its address.
REQ-015 SHALL have port pixel_on  output  1  registered sprite-pixel hit for the current pixel.
REQ-016 SHALL have port busy  output  1  high while the render FSM is not IDLE.
REQ-017 SHALL have port overrun  output  1  one-cycle pulse when a buffer swap interrupts a render.

Function
REQ-018 SHALL hold two LINE_PIXELS-bit line buffers, front (displayed) and back (rendered), with a one-bit select.
REQ-019 SHALL start a render on line_start when pix_y[1:0]==2'b11, target line T = 0 if pix_y==V_LAST, else pix_y[9:2]+1 (8-bit).
REQ-020 SHALL swap front/back on line_start when pix_y[1:0]==2'b00, the same cycle a start would otherwise be evaluated.
REQ-021 SHALL use FSM states IDLE, CLEAR, OBJ_RD, CHECK, PIX_ADDR, PIX_DATA, NEXT.
REQ-022 IDLE -> CLEAR on start; CLEAR zeroes all back-buffer bits in one cycle, sets sprite index 0, -> OBJ_RD.
REQ-023 OBJ_RD SHALL issue addresses idx*4+0..3 on consecutive cycles and capture x, y, offset, size one cycle later each, then -> CHECK.
REQ-024 CHECK: width = size[7:4]+1, height = size[3:0]+1; hit when T >= y and T < y+height (9-bit sum, no wrap); hit -> PIX_ADDR with sx=0, miss -> NEXT.
REQ-025 PIX_ADDR: bit_offset = (T-y)*width + sx (8-bit); byte address = offset + bit_offset[7:3] (9-bit); drive bmp_rd_addr with its low 6 bits; -> PIX_DATA.
REQ-026 PIX_DATA: set back[x+sx] when bmp_rd_data[bit_offset[2:0]]==1, byte address < BITMAP_BYTES, and x+sx < LINE_PIXELS (9-bit); never clear bits; sx+1 < width -> PIX_ADDR, else -> NEXT.
REQ-027 NEXT: idx+1 < MAX_SPRITES -> OBJ_RD with idx+1, else -> IDLE.
REQ-028 Overlapping sprites SHALL OR into the buffer; no priority.
REQ-029 A swap while not IDLE SHALL complete the swap, pulse overrun for one cycle, and force the FSM to IDLE.
REQ-030 A start while not IDLE SHALL be ignored.
REQ-031 pixel_on SHALL register visible & front[pix_x[9:2]] each cycle (1-cycle latency); index >= LINE_PIXELS yields 0.
REQ-032 obj_rd_addr and bmp_rd_addr SHALL be 0 when not driven by OBJ_RD or PIX_ADDR.

Reset
REQ-033 On rst_n low: FSM IDLE, both buffers 0, select 0, pixel_on 0, busy 0, overrun 0, all address outputs 0, captured attributes 0.
REQ-034 Reset assertion mid-render SHALL abort immediately with no partial buffer write after deassertion.

Verification
REQ-035 Sprite x=10,y=5,size=0x00,offset=0, bitmap[0]=0x01, start at pix_y=19 -> after swap at pix_y=20, pixel_on=1 only for pix_x 40..43 on lines 20..23, one cycle late.
REQ-036 Sprite size=0x77 (8x8), offset=2, bitmap[2+r]=0xFF for rows r, T=y+3 -> back bits x..x+7 set; bmp_rd_addr reads 5 eight times.
REQ-037 Sprite x=156, width 8, all bits set -> only logical pixels 156..159 set, no wrap to 0.
REQ-038 Byte address >= 55 (offset=54, bit_offset>=8) -> those pixels stay 0.
REQ-039 pix_y=524 start -> renders T=0; sprite at y=0 visible on physical lines 0..3 of next frame.
REQ-040 Line_start with pix_y[1:0]=00 forced while busy -> overrun pulses once, busy drops next cycle, front buffer swapped.
